// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file for the RISC-V core.
// 3 combinational read ports (A/B/C), 2 synchronous write ports (0/1),
// optional x0 hard-zero, optional write-to-read bypass and a per-register
// busy scoreboard set at issue and cleared at writeback.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   sa, sb, sc                 read addresses
//   data_a, data_b, data_c     read data (combinational)
//   busy_a, busy_b, busy_c     scoreboard bit of the read address (combinational)
//   ld0, dr0, d_in0            write port 0: enable, address, data
//   ld1, dr1, d_in1            write port 1: enable, address, data (wins on collision)
//   issue_en, issue_dr         mark a register busy (pending writeback)
//   wr_conflict                registered: both ports wrote the same register last cycle
module register_file_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   sa,
    input  logic [AW-1:0]   sb,
    input  logic [AW-1:0]   sc,
    output logic [XLEN-1:0] data_a,
    output logic [XLEN-1:0] data_b,
    output logic [XLEN-1:0] data_c,
    output logic            busy_a,
    output logic            busy_b,
    output logic            busy_c,
    input  logic            ld0,
    input  logic [AW-1:0]   dr0,
    input  logic [XLEN-1:0] d_in0,
    input  logic            ld1,
    input  logic [AW-1:0]   dr1,
    input  logic [XLEN-1:0] d_in1,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_dr,
    output logic            wr_conflict
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    // Qualified enables: register 0 is untouchable under ZERO_REG, and
    // nothing takes effect (including bypass) while reset is asserted.
    logic we0, we1, iss;

    always_comb begin
        we0 = ld0 & rst_n;
        we1 = ld1 & rst_n;
        iss = issue_en & rst_n;
        if (ZERO_REG) begin
            if (dr0 == '0)      we0 = 1'b0;
            if (dr1 == '0)      we1 = 1'b0;
            if (issue_dr == '0) iss = 1'b0;
        end
    end

    // Read value for one port: stored value, overridden by an incoming
    // write when bypass is enabled (port 1 applied last so it wins).
    function automatic logic [XLEN-1:0] rd_val(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] stored,
        input logic            w0,
        input logic [AW-1:0]   a0,
        input logic [XLEN-1:0] v0,
        input logic            w1,
        input logic [AW-1:0]   a1,
        input logic [XLEN-1:0] v1
    );
        logic [XLEN-1:0] r;
        r = stored;
        if (BYPASS) begin
            if (w0 && (a0 == addr)) r = v0;
            if (w1 && (a1 == addr)) r = v1;
        end
        if (ZERO_REG && (addr == '0)) r = '0;
        return r;
    endfunction

    assign data_a = rd_val(sa, regs[sa], we0, dr0, d_in0, we1, dr1, d_in1);
    assign data_b = rd_val(sb, regs[sb], we0, dr0, d_in0, we1, dr1, d_in1);
    assign data_c = rd_val(sc, regs[sc], we0, dr0, d_in0, we1, dr1, d_in1);

    // Busy reflects registered state only; bit 0 is never set under ZERO_REG.
    assign busy_a = busy[sa];
    assign busy_b = busy[sb];
    assign busy_c = busy[sc];

    // Register array, scoreboard and conflict flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
            busy        <= '0;
            wr_conflict <= 1'b0;
        end else begin
            if (we0) regs[dr0] <= d_in0;
            if (we1) regs[dr1] <= d_in1;
            // Clears first so a same-cycle issue to the same register wins.
            if (we0) busy[dr0] <= 1'b0;
            if (we1) busy[dr1] <= 1'b0;
            if (iss) busy[issue_dr] <= 1'b1;
            wr_conflict <= we0 & we1 & (dr0 == dr1);
        end
    end

endmodule
